// File: rtl/mantissa_adder_if.sv
// mantissa_adder_if: adder callee handshake between the FP adder controller and the mantissa adder.
interface mantissa_adder_if #(parameter int WIDTH = 24);
    logic [WIDTH-1:0] Adder_datain1;
    logic [WIDTH-1:0] Adder_datain2;
    logic             Adder_valid;
    logic [WIDTH-1:0] Adder_dataout;
    logic             Adder_carryout;
    logic [1:0]       Adder_Exc;
    logic             Adder_ack;
    modport master (
        output Adder_datain1, Adder_datain2, Adder_valid,
        input  Adder_dataout, Adder_carryout, Adder_Exc, Adder_ack
    );
    modport slave (
        input  Adder_datain1, Adder_datain2, Adder_valid,
        output Adder_dataout, Adder_carryout, Adder_Exc, Adder_ack
    );
endinterface

// File: rtl/mantissa_adder.sv
// mantissa_adder: chunk-serial unsigned adder, LSB chunk first, with registered inter-chunk carry.
module mantissa_adder #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 8
) (
    input logic CLK,
    input logic RSTn,
    mantissa_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int KW = $clog2(N + 1);
    localparam int CW = CHUNK + 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a, b, sum, sum_nx;
    logic carry, last;
    logic [KW-1:0] k;
    logic [CHUNK:0] chunk;
    always_comb begin
        last = k == KW'(N - 1);
        chunk = {1'b0, a[k*CHUNK +: CHUNK]} + {1'b0, b[k*CHUNK +: CHUNK]} + CW'(carry);
        sum_nx = sum;
        sum_nx[k*CHUNK +: CHUNK] = chunk[CHUNK-1:0];
    end
    always_ff @(posedge CLK)
        if (RSTn) state <= IDLE;
        else      state <= state_nx;
    always_comb
        state_nx = state == IDLE ? (bus.Adder_valid ? CALC : IDLE) :
                   state == CALC ? (!bus.Adder_valid ? IDLE : last ? DONE : CALC) :
                   (bus.Adder_valid ? DONE : IDLE);
    always_comb bus.Adder_ack = state == DONE;
    // Results publish only on the final chunk edge; an abort leaves them untouched.
    always_ff @(posedge CLK) begin
        if (RSTn) begin
            a <= '0;
            b <= '0;
            sum <= '0;
            carry <= 1'b0;
            k <= '0;
            bus.Adder_dataout <= '0;
            bus.Adder_carryout <= 1'b0;
            bus.Adder_Exc <= 2'b00;
        end else if (state == IDLE && bus.Adder_valid) begin
            a <= bus.Adder_datain1;
            b <= bus.Adder_datain2;
            sum <= '0;
            carry <= 1'b0;
            k <= '0;
        end else if (state == CALC && bus.Adder_valid) begin
            sum <= sum_nx;
            carry <= chunk[CHUNK];
            k <= k + 1'b1;
            if (last) begin
                bus.Adder_dataout <= sum_nx;
                bus.Adder_carryout <= chunk[CHUNK];
                bus.Adder_Exc <= (sum_nx == '0 && !chunk[CHUNK]) ? 2'b01 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_mantissa_adder.sv
// tb_mantissa_adder: directed vectors against a one-shot arithmetic model of the mantissa adder.
module tb_mantissa_adder;
    localparam int N = 3;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    int total = 0, passed = 0;
    bit started = 1'b0;
    mantissa_adder_if #(.WIDTH(24)) bus ();
    mantissa_adder #(.WIDTH(24), .CHUNK(8)) dut (.CLK(clk), .RSTn(rstn), .bus(bus));
    always #5 clk = ~clk;
    // model: whole sum computed in one step at capture, published N calc edges later
    int m_ph, m_cnt;
    logic [24:0] m_res;
    logic [23:0] m_out;
    logic m_cy;
    logic [1:0] m_exc;
    always @(posedge clk) begin
        if (rstn) begin
            m_ph <= 0; m_cnt <= 0; m_res <= '0; m_out <= '0; m_cy <= 1'b0; m_exc <= 2'b00;
        end else if (m_ph == 0) begin
            if (bus.Adder_valid) begin
                m_res <= {1'b0, bus.Adder_datain1} + {1'b0, bus.Adder_datain2};
                m_cnt <= N;
                m_ph <= 1;
            end
        end else if (m_ph == 1) begin
            if (!bus.Adder_valid) m_ph <= 0;
            else if (m_cnt == 1) begin
                m_out <= m_res[23:0];
                m_cy <= m_res[24];
                m_exc <= (m_res == 25'd0) ? 2'b01 : 2'b00;
                m_ph <= 2;
            end else m_cnt <= m_cnt - 1;
        end else if (!bus.Adder_valid) m_ph <= 0;
    end
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask
    always @(negedge clk)
        if (started) begin
            check("model_dataout", 32'(bus.Adder_dataout), 32'(m_out));
            check("model_carry", 32'(bus.Adder_carryout), 32'(m_cy));
            check("model_exc", 32'(bus.Adder_Exc), 32'(m_exc));
            check("model_ack", 32'(bus.Adder_ack), 32'(m_ph == 2));
        end
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.Adder_ack && n < 20);
    endtask
    task automatic op(input logic [23:0] a, input logic [23:0] b, input int hold,
                      input logic [23:0] eo, input logic ec, input logic [1:0] ee);
        int n;
        bus.Adder_datain1 = a;
        bus.Adder_datain2 = b;
        bus.Adder_valid = 1'b1;
        @(negedge clk);
        n = 1;
        bus.Adder_datain1 = 24'hFFFFFF;
        bus.Adder_datain2 = 24'hFFFFFF;
        while (!bus.Adder_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd4);
        check("dataout", 32'(bus.Adder_dataout), 32'(eo));
        check("carryout", 32'(bus.Adder_carryout), 32'(ec));
        check("exc", 32'(bus.Adder_Exc), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_ack", 32'(bus.Adder_ack), 32'd1);
            check("hold_dataout", 32'(bus.Adder_dataout), 32'(eo));
        end
        bus.Adder_valid = 1'b0;
        @(negedge clk);
        check("ack_release", 32'(bus.Adder_ack), 32'd0);
    endtask
    task automatic reset_check;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_dataout", 32'(bus.Adder_dataout), 32'd0);
        check("rst_carry", 32'(bus.Adder_carryout), 32'd0);
        check("rst_exc", 32'(bus.Adder_Exc), 32'd0);
        check("rst_ack", 32'(bus.Adder_ack), 32'd0);
        bus.Adder_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        int n;
        bus.Adder_datain1 = '0;
        bus.Adder_datain2 = '0;
        bus.Adder_valid = 1'b0;
        @(negedge clk);
        started = 1'b1;
        reset_check();
        op(24'h123456, 24'h654321, 0, 24'h777777, 1'b0, 2'b00);
        op(24'hFFFFFF, 24'h000001, 0, 24'h000000, 1'b1, 2'b00);
        op(24'h800000, 24'hC00000, 0, 24'h400000, 1'b1, 2'b00);
        op(24'h000000, 24'h000000, 0, 24'h000000, 1'b0, 2'b01);
        op(24'h000010, 24'h000020, 0, 24'h000030, 1'b0, 2'b00);
        // abort after one calc edge
        bus.Adder_datain1 = 24'h0F0F0F;
        bus.Adder_datain2 = 24'h0F0F0F;
        bus.Adder_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.Adder_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_ack", 32'(bus.Adder_ack), 32'd0);
        check("abort_dataout", 32'(bus.Adder_dataout), 32'h000030);
        op(24'h0F0F0F, 24'h010101, 0, 24'h101010, 1'b0, 2'b00);
        // reset mid-CALC
        bus.Adder_datain1 = 24'h111111;
        bus.Adder_datain2 = 24'h222222;
        bus.Adder_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset_check();
        // reset in DONE
        bus.Adder_datain1 = 24'hABCDEF;
        bus.Adder_datain2 = 24'h000001;
        bus.Adder_valid = 1'b1;
        wait_ack(n);
        check("done_ack", 32'(bus.Adder_ack), 32'd1);
        check("done_dataout", 32'(bus.Adder_dataout), 32'hABCDF0);
        reset_check();
        op(24'h00FF00, 24'h00FF00, 5, 24'h01FE00, 1'b0, 2'b00);
        op(24'h000001, 24'h000001, 0, 24'h000002, 1'b0, 2'b00);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
